// File: rtl/ap_fifo_frame_tagger_pkg.sv
// Shared definitions for the ap_fifo frame tagger: magics, field ranges, states, trailer layout.
package ap_fifo_frame_tagger_pkg;

  localparam int unsigned DW    = 128;
  localparam int unsigned SEQ_W = 32;
  localparam int unsigned LEN_W = 32;
  localparam int unsigned ERR_W = 16;
  localparam int unsigned FRM_W = 32;

  localparam logic [LEN_W-1:0] MAX_LEN   = 32'd65536;
  localparam logic [31:0]      HDR_MAGIC = 32'h48434F44;
  localparam logic [31:0]      TRL_MAGIC = 32'h454E4421;

  // Header field bit ranges
  localparam int unsigned HDR_MAGIC_HI = 127;
  localparam int unsigned HDR_MAGIC_LO = 96;
  localparam int unsigned HDR_LEN_HI   = 31;
  localparam int unsigned HDR_LEN_LO   = 0;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PAY = 2'd1,
    S_TRL = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]      magic;
    logic [SEQ_W-1:0] seq;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      csum;
  } trl_t;

  // A header is accepted only with the right magic and a length we can carry.
  function automatic logic hdr_valid(input logic [31:0] magic, input logic [LEN_W-1:0] len);
    return (magic == HDR_MAGIC) && (len <= MAX_LEN);
  endfunction

  // XOR of the four 32-bit lanes of a stream word.
  function automatic logic [31:0] lane_xor(input logic [DW-1:0] w);
    return w[127:96] ^ w[95:64] ^ w[63:32] ^ w[31:0];
  endfunction

endpackage

// File: rtl/frame_csum32.sv
// Registered 32-bit lane-XOR accumulator with synchronous clear and enable.
module frame_csum32
  import ap_fifo_frame_tagger_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] word,
  output logic [31:0]   csum
);

  // Clear wins over accumulate so a new frame always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      csum <= '0;
    end else if (en) begin
      csum <= csum ^ lane_xor(word);
    end
  end

endmodule

// File: rtl/ap_fifo_frame_tagger.sv
// Stream stage: validates frame headers, forwards header + payload, appends a trailer word.
module ap_fifo_frame_tagger
  import ap_fifo_frame_tagger_pkg::*;
(
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [DW-1:0]    in_V_V_dout,
  input  logic             in_V_V_empty_n,
  output logic             in_V_V_read,
  output logic [DW-1:0]    out_V_V_din,
  input  logic             out_V_V_full_n,
  output logic             out_V_V_write,
  output logic [FRM_W-1:0] frame_cnt,
  output logic [ERR_W-1:0] hdr_err_cnt,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_inc;
  logic [SEQ_W-1:0] seq_q;
  logic [31:0]      csum_q;
  logic             post_rst_q;
  logic             hold;
  logic             hdr_ok;
  logic [LEN_W-1:0] hdr_len;
  logic             len_ld, csum_en, err_inc, frame_done;
  trl_t             trl;

  assign hold    = ap_rst | post_rst_q;
  assign hdr_len = in_V_V_dout[HDR_LEN_HI:HDR_LEN_LO];
  assign hdr_ok  = hdr_valid(in_V_V_dout[HDR_MAGIC_HI:HDR_MAGIC_LO], hdr_len);
  assign cnt_inc = cnt_q + LEN_W'(1);
  assign busy    = (state_q != S_HDR);
  assign trl     = '{magic: TRL_MAGIC, seq: seq_q, cnt: cnt_q, csum: csum_q};

  // Payload checksum for the current frame.
  frame_csum32 u_csum (
    .clk  (ap_clk),
    .rst  (ap_rst),
    .clr  (len_ld),
    .en   (csum_en),
    .word (in_V_V_dout),
    .csum (csum_q)
  );

  // State register; the handshake is held off for one cycle after reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= S_HDR;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      post_rst_q <= 1'b0;
    end
  end

  // Frame length, word count, sequence number and the two status counters.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      len_q       <= '0;
      cnt_q       <= '0;
      seq_q       <= '0;
      frame_cnt   <= '0;
      hdr_err_cnt <= '0;
    end else begin
      if (len_ld) begin
        len_q <= hdr_len;
        cnt_q <= '0;
      end else if (csum_en) begin
        cnt_q <= cnt_inc;
      end
      if (frame_done) begin
        seq_q     <= seq_q + SEQ_W'(1);
        frame_cnt <= frame_cnt + FRM_W'(1);
      end
      if (err_inc && (hdr_err_cnt != '1)) begin
        hdr_err_cnt <= hdr_err_cnt + ERR_W'(1);
      end
    end
  end

  // Next state and combinational handshake; bad headers are popped without a write.
  always_comb begin
    state_d       = state_q;
    in_V_V_read   = 1'b0;
    out_V_V_write = 1'b0;
    out_V_V_din   = in_V_V_dout;
    len_ld        = 1'b0;
    csum_en       = 1'b0;
    err_inc       = 1'b0;
    frame_done    = 1'b0;
    if (!hold) begin
      case (state_q)
        S_HDR: begin
          if (in_V_V_empty_n) begin
            if (hdr_ok) begin
              if (out_V_V_full_n) begin
                in_V_V_read   = 1'b1;
                out_V_V_write = 1'b1;
                len_ld        = 1'b1;
                state_d       = (hdr_len == LEN_W'(0)) ? S_TRL : S_PAY;
              end
            end else begin
              in_V_V_read = 1'b1;
              err_inc     = 1'b1;
            end
          end
        end
        S_PAY: begin
          if (in_V_V_empty_n && out_V_V_full_n) begin
            in_V_V_read   = 1'b1;
            out_V_V_write = 1'b1;
            csum_en       = 1'b1;
            if (cnt_inc == len_q) begin
              state_d = S_TRL;
            end
          end
        end
        S_TRL: begin
          out_V_V_din   = trl;
          out_V_V_write = out_V_V_full_n;
          if (out_V_V_full_n) begin
            frame_done = 1'b1;
            state_d    = S_HDR;
          end
        end
        default: state_d = S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_fifo_frame_tagger.sv
// Self-checking bench for ap_fifo_frame_tagger: decode table, directed frames, random stream vs. model.
module tb_ap_fifo_frame_tagger;

  localparam logic [31:0] HM      = 32'h48434F44;
  localparam logic [31:0] TM      = 32'h454E4421;
  localparam logic [31:0] MAXL    = 32'd65536;
  localparam logic [31:0] BAD_MAG = 32'hDEADBEEF;

  logic         ap_clk;
  logic         ap_rst;
  logic [127:0] in_dout;
  logic         in_empty_n;
  logic         in_read;
  logic [127:0] out_din;
  logic         out_full_n;
  logic         out_write;
  logic [31:0]  frame_cnt;
  logic [15:0]  hdr_err_cnt;
  logic         busy;

  int errors = 0;
  int checks = 0;

  ap_fifo_frame_tagger dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .in_V_V_dout    (in_dout),
    .in_V_V_empty_n (in_empty_n),
    .in_V_V_read    (in_read),
    .out_V_V_din    (out_din),
    .out_V_V_full_n (out_full_n),
    .out_V_V_write  (out_write),
    .frame_cnt      (frame_cnt),
    .hdr_err_cnt    (hdr_err_cnt),
    .busy           (busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [127:0] dout;
    logic         empty_n;
    logic         full_n;
    logic         exp_rd;
    logic         exp_wr;
  } vec_t;

  vec_t         vecs[10];
  logic [127:0] src_q[$];
  logic [127:0] consumed_q[$];
  logic [127:0] out_q[$];
  logic [127:0] exp_q[$];
  logic [31:0]  m_seq;
  logic [31:0]  m_frames;
  logic [15:0]  m_errs;
  int           viol;
  int           pushed;
  logic         timed_out;
  logic [127:0] bp_w[5];
  logic [127:0] tmp;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] hdr(input logic [31:0] n, input logic [63:0] mid);
    return {HM, mid, n};
  endfunction

  function automatic logic [127:0] trl(input logic [31:0] s, input logic [31:0] n, input logic [31:0] x);
    return {TM, s, n, x};
  endfunction

  function automatic logic [31:0] lanes(input logic [127:0] w);
    return w[127:96] ^ w[95:64] ^ w[63:32] ^ w[31:0];
  endfunction

  // One cycle: drive at negedge, check the combinational handshake before the posedge.
  task automatic xfer(input string nm, input logic [127:0] d, input logic e, input logic f,
                      input logic er, input logic ew, input logic [127:0] ed);
    @(negedge ap_clk);
    in_dout    = d;
    in_empty_n = e;
    out_full_n = f;
    #2;
    chk({nm, "_rd"}, 128'(in_read), 128'(er));
    chk({nm, "_wr"}, 128'(out_write), 128'(ew));
    if (ew) chk({nm, "_din"}, out_din, ed);
  endtask

  task automatic idle();
    @(negedge ap_clk);
    in_empty_n = 1'b0;
    out_full_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst     = 1'b1;
    in_empty_n = 1'b0;
    out_full_n = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  // Reference: parse the consumed word stream into the expected output stream and counters.
  task automatic build_expected();
    int unsigned i;
    logic [127:0] w;
    logic [31:0]  n;
    logic [31:0]  x;
    i = 0;
    exp_q.delete();
    while (i < consumed_q.size()) begin
      w = consumed_q[i];
      i++;
      n = w[31:0];
      if (w[127:96] == HM && n <= MAXL) begin
        exp_q.push_back(w);
        x = '0;
        for (int k = 0; k < int'(n); k++) begin
          if (i < consumed_q.size()) begin
            exp_q.push_back(consumed_q[i]);
            x ^= lanes(consumed_q[i]);
            i++;
          end
        end
        exp_q.push_back(trl(m_seq, n, x));
        m_seq++;
        m_frames++;
      end else if (m_errs != 16'hFFFF) begin
        m_errs++;
      end
    end
  endtask

  // Random driver with starvation and backpressure; records every transfer.
  task automatic run_stream(input int budget, input int p_starve, input int p_bp);
    int cyc;
    cyc = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (src_q.size() == 0 && !busy) break;
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      cyc++;
      in_empty_n = (src_q.size() > 0) && ($urandom_range(99) >= p_starve);
      in_dout    = (src_q.size() > 0) ? src_q[0] : {$urandom, $urandom, $urandom, $urandom};
      out_full_n = ($urandom_range(99) >= p_bp);
      #2;
      if (in_read && !in_empty_n) viol++;
      if (out_write && !out_full_n) viol++;
      if (in_read && out_write && out_din !== in_dout) viol++;
      if (busy && in_read && !out_write) viol++;
      if (in_read) begin
        consumed_q.push_back(in_dout);
        void'(src_q.pop_front());
      end
      if (out_write) out_q.push_back(out_din);
    end
    in_empty_n = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] n;
    int          idx;
    int          k;
    logic        f;

    ap_rst     = 1'b1;
    in_empty_n = 1'b1;
    out_full_n = 1'b1;
    in_dout    = hdr(32'd3, 64'h0);

    // Reset: no handshake during reset nor the cycle after.
    repeat (2) @(negedge ap_clk);
    #2;
    chk("rst_rd", 128'(in_read), 128'(0));
    chk("rst_wr", 128'(out_write), 128'(0));
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #2;
    chk("post_rst_rd", 128'(in_read), 128'(0));
    chk("post_rst_wr", 128'(out_write), 128'(0));
    chk("rst_frame_cnt", 128'(frame_cnt), 128'(0));
    chk("rst_err_cnt", 128'(hdr_err_cnt), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    #1 in_empty_n = 1'b0;

    // Header decode table, sampled then withdrawn before the edge.
    vecs[0] = '{hdr(32'd3, 64'h1), 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{hdr(32'd3, 64'h1), 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{hdr(32'd3, 64'h1), 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{{BAD_MAG, 96'h3}, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{{BAD_MAG, 96'h3}, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{hdr(MAXL, 64'h2), 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{hdr(MAXL + 32'd1, 64'h2), 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{hdr(32'hFFFFFFFF, 64'h2), 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{{HM ^ 32'h1, 64'h0, 32'd1}, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{{BAD_MAG, 96'h0}, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      in_dout    = vecs[i].dout;
      in_empty_n = vecs[i].empty_n;
      out_full_n = vecs[i].full_n;
      #2;
      chk($sformatf("vec%0d_rd", i), 128'(in_read), 128'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_wr", i), 128'(out_write), 128'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) chk($sformatf("vec%0d_din", i), out_din, vecs[i].dout);
      #1 in_empty_n = 1'b0;
    end
    idle();
    chk("table_err_cnt", 128'(hdr_err_cnt), 128'(0));

    // Nominal N=3 frame, payload 1,2,3 in lane 0.
    xfer("nom_hdr", hdr(32'd3, 64'hA5A5), 1'b1, 1'b1, 1'b1, 1'b1, hdr(32'd3, 64'hA5A5));
    xfer("nom_p1", 128'd1, 1'b1, 1'b1, 1'b1, 1'b1, 128'd1);
    xfer("nom_p2", 128'd2, 1'b1, 1'b1, 1'b1, 1'b1, 128'd2);
    xfer("nom_p3", 128'd3, 1'b1, 1'b1, 1'b1, 1'b1, 128'd3);
    xfer("nom_trl", 128'd0, 1'b0, 1'b1, 1'b0, 1'b1, trl(32'd0, 32'd3, 32'd0));
    idle();
    chk("nom_frame_cnt", 128'(frame_cnt), 128'(1));

    // N=0: trailer follows immediately and consumes no input even when offered.
    xfer("n0_hdr", hdr(32'd0, 64'h77), 1'b1, 1'b1, 1'b1, 1'b1, hdr(32'd0, 64'h77));
    xfer("n0_trl", hdr(32'd5, 64'h0), 1'b1, 1'b1, 1'b0, 1'b1, trl(32'd1, 32'd0, 32'd0));
    idle();
    chk("n0_frame_cnt", 128'(frame_cnt), 128'(2));

    // Bad magic under backpressure is still dropped; next header forwards normally.
    xfer("bad_hdr", {BAD_MAG, 96'h123}, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0);
    xfer("bad_next_hdr", hdr(32'd0, 64'h5), 1'b1, 1'b1, 1'b1, 1'b1, hdr(32'd0, 64'h5));
    xfer("bad_next_trl", 128'd0, 1'b0, 1'b1, 1'b0, 1'b1, trl(32'd2, 32'd0, 32'd0));
    idle();
    chk("bad_err_cnt", 128'(hdr_err_cnt), 128'(1));
    chk("bad_frame_cnt", 128'(frame_cnt), 128'(3));

    // Backpressure N=4 with full_n pattern 1,0,0,1,...; read tracks write every cycle.
    bp_w[0] = hdr(32'd4, 64'hBEEF);
    for (int j = 1; j <= 4; j++) begin
      tmp = 128'(j);
      bp_w[j] = tmp << (32 * (j - 1));
    end
    idx = 0;
    k = 0;
    while (idx < 6 && k < 40) begin
      f = (k % 3 == 0);
      if (idx < 5) xfer($sformatf("bp%0d", idx), bp_w[idx], 1'b1, f, f, f, bp_w[idx]);
      else xfer("bp_trl", 128'd0, 1'b0, f, 1'b0, f, trl(32'd3, 32'd4, 32'd4));
      if (f) idx++;
      k++;
    end
    idle();
    chk("bp_frame_cnt", 128'(frame_cnt), 128'(4));

    // Starvation mid-frame, then reset discards the partial frame.
    xfer("st_hdr", hdr(32'd8, 64'h0), 1'b1, 1'b1, 1'b1, 1'b1, hdr(32'd8, 64'h0));
    for (int j = 1; j <= 3; j++) xfer("st_pay", 128'(j), 1'b1, 1'b1, 1'b1, 1'b1, 128'(j));
    for (int j = 0; j < 5; j++) xfer("st_starve", 128'd9, 1'b0, 1'b1, 1'b0, 1'b0, 128'd0);
    chk("st_busy", 128'(busy), 128'(1));
    do_reset();
    #2;
    chk("st_rst_frame_cnt", 128'(frame_cnt), 128'(0));
    chk("st_rst_err_cnt", 128'(hdr_err_cnt), 128'(0));
    chk("st_rst_busy", 128'(busy), 128'(0));
    xfer("st_new_hdr", hdr(32'd0, 64'h9), 1'b1, 1'b1, 1'b1, 1'b1, hdr(32'd0, 64'h9));
    xfer("st_new_trl", 128'd0, 1'b0, 1'b1, 1'b0, 1'b1, trl(32'd0, 32'd0, 32'd0));

    // Random stream checked against the stream-level reference.
    do_reset();
    m_seq = '0;
    m_frames = '0;
    m_errs = '0;
    viol = 0;
    consumed_q.delete();
    out_q.delete();
    src_q.delete();
    for (int fr = 0; fr < 30; fr++) begin
      r = $urandom_range(9);
      if (r < 2) begin
        n = $urandom;
        if (n == HM) n = ~n;
        src_q.push_back({n, $urandom, $urandom, $urandom});
      end else if (r == 2) begin
        src_q.push_back(hdr(MAXL + 32'd1 + 32'($urandom_range(1000)), {$urandom, $urandom}));
      end else begin
        n = 32'($urandom_range(6));
        src_q.push_back(hdr(n, {$urandom, $urandom}));
        for (int j = 0; j < int'(n); j++) src_q.push_back({$urandom, $urandom, $urandom, $urandom});
      end
    end
    pushed = src_q.size();
    run_stream(5000, 20, 30);
    chk("rnd_timeout", 128'(timed_out), 128'(0));
    chk("rnd_consumed", 128'(consumed_q.size()), 128'(pushed));
    build_expected();
    chk("rnd_out_len", 128'(out_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk($sformatf("rnd_word%0d", i), out_q[i], exp_q[i]);
    chk("rnd_frame_cnt", 128'(frame_cnt), 128'(m_frames));
    chk("rnd_err_cnt", 128'(hdr_err_cnt), 128'(m_errs));
    chk("rnd_protocol", 128'(viol), 128'(0));

    // Sequence wrap from a preloaded all-ones value.
    do_reset();
    force dut.seq_q = 32'hFFFFFFFF;
    @(posedge ap_clk);
    #1 release dut.seq_q;
    xfer("wr_hdr", hdr(32'd1, 64'h0), 1'b1, 1'b1, 1'b1, 1'b1, hdr(32'd1, 64'h0));
    xfer("wr_pay", 128'h5, 1'b1, 1'b1, 1'b1, 1'b1, 128'h5);
    xfer("wr_trl", 128'd0, 1'b0, 1'b1, 1'b0, 1'b1, trl(32'hFFFFFFFF, 32'd1, 32'd5));
    xfer("wr_hdr2", hdr(32'd0, 64'h0), 1'b1, 1'b1, 1'b1, 1'b1, hdr(32'd0, 64'h0));
    xfer("wr_trl2", 128'd0, 1'b0, 1'b1, 1'b0, 1'b1, trl(32'd0, 32'd0, 32'd0));

    // Error counter saturation over 70000 dropped headers.
    @(negedge ap_clk);
    in_dout    = {BAD_MAG, 96'h0};
    in_empty_n = 1'b1;
    out_full_n = 1'b0;
    repeat (65534) @(posedge ap_clk);
    #1 chk("sat_fffe", 128'(hdr_err_cnt), 128'(16'hFFFE));
    @(posedge ap_clk);
    #1 chk("sat_ffff", 128'(hdr_err_cnt), 128'(16'hFFFF));
    repeat (4465) @(posedge ap_clk);
    #1 chk("sat_hold", 128'(hdr_err_cnt), 128'(16'hFFFF));
    chk("sat_frame_cnt", 128'(frame_cnt), 128'(2));
    chk("sat_busy", 128'(busy), 128'(0));
    in_empty_n = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
